// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the memory port controller.
// Holds the controller state enum, the default widths and the wait-counter width.
package mem_port_pkg;

    localparam int unsigned DefDataW      = 16;
    localparam int unsigned DefAddrW      = 16;
    localparam int unsigned DefWaitCycles = 1;
    localparam int unsigned DefMemDepth   = 256;

    // Wait counter width; holds WAIT_CYCLES values up to 15.
    localparam int unsigned CntW = 4;

    // Controller states: IDLE, ISSUE, WAIT, RESP.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_port_wait_cnt.sv
// SRAM read-latency down-counter for the memory port controller.
// Loads a start value, decrements on request and saturates at zero.
module mem_port_wait_cnt
    import mem_port_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic [CntW-1:0] load_val,
    input  logic            dec,
    output logic [CntW-1:0] count,
    output logic            zero
);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement; never step below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-outstanding request controller in front of a synchronous SRAM.
// Request -> ISSUE (one mem_en cycle) -> WAIT (WAIT_CYCLES) -> RESP (one rsp_valid pulse).
// Optional feature macro: MEM_PORT_ERR_EN (out-of-range addresses answer with rsp_err).
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles,
    parameter int unsigned MEM_DEPTH   = DefMemDepth
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15) || (MEM_DEPTH < 1)) begin : g_bad_param
        $error("mem_port_ctrl: illegal WAIT_CYCLES or MEM_DEPTH");
    end

    state_e            state_q, state_d;
    logic              accept;
    logic              addr_err;
    logic              last_wait;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [CntW-1:0]   cnt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;

`ifdef MEM_PORT_ERR_EN
    assign addr_err = (32'(req_addr) >= MEM_DEPTH);
`else
    assign addr_err = 1'b0;
`endif

    // Counter holds WAIT_CYCLES on the first WAIT cycle, so a count of 1 marks the last one.
    assign cnt_load  = (state_q == StIssue);
    assign cnt_dec   = (state_q == StWait) && !cnt_zero;
    assign last_wait = (state_q == StWait) && (cnt <= CntW'(1));

    mem_port_wait_cnt u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CntW'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = addr_err ? StResp : StIssue;
            StIssue: state_d = StWait;
            StWait:  if (last_wait) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register and registered SRAM strobes (asserted only for the ISSUE cycle).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_en_q <= (state_d == StIssue);
            mem_we_q <= (state_d == StIssue) && req_write;
        end
    end

    // Request latch; these registers also drive the SRAM address and write data.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Response data capture; held until the next capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (last_wait) begin
            rdata_q <= write_q ? '0 : mem_rdata;
`ifdef MEM_PORT_ERR_EN
        end else if (accept && addr_err) begin
            rdata_q <= '0;
`endif
        end
    end

`ifdef MEM_PORT_ERR_EN
    logic err_q;

    // Error flag captured alongside the response data.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (last_wait) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= addr_err;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed steps plus randomized transactions
// compared against a transaction-level model (latency rule + word array).
module tb_mem_port_ctrl;

    localparam int unsigned WAIT  = 4;
    localparam int unsigned DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_mem [0:255];

    always #5 clock = ~clock;

    mem_port_ctrl #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .WAIT_CYCLES (WAIT),
        .MEM_DEPTH   (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous SRAM device: read data valid WAIT cycles after the mem_en cycle, junk otherwise.
    logic [15:0]     sram [0:255];
    logic [15:0]     rd_pipe [0:WAIT-1];
    logic [WAIT-1:0] rd_vld;
    logic [15:0]     junk;
    logic            pre_we = 1'b0;
    logic [7:0]      pre_addr = '0;
    logic [15:0]     pre_data = '0;

    always @(posedge clock) begin
        junk <= 16'($urandom);
        if (pre_we) sram[pre_addr] <= pre_data;
        else if (mem_en && mem_we) sram[mem_addr[7:0]] <= mem_wdata;
        rd_pipe[0] <= sram[mem_addr[7:0]];
        rd_vld[0]  <= mem_en && !mem_we;
        for (int i = 1; i < WAIT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_vld[i]  <= rd_vld[i-1];
        end
    end

    assign mem_rdata = rd_vld[WAIT-1] ? rd_pipe[WAIT-1] : junk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction; junk requests are offered while busy and must be ignored.
    task automatic transact(input logic w, input logic [15:0] a, input logic [15:0] d);
        logic        err;
        int          lat;
        logic [15:0] exp_rd;
        err = 1'b0;
`ifdef MEM_PORT_ERR_EN
        err = (32'(a) >= DEPTH);
`endif
        lat    = err ? 1 : WAIT + 2;
        exp_rd = (err || w) ? 16'h0000 : ref_mem[a[7:0]];
        if (w && !err) ref_mem[a[7:0]] = d;
        chk_bit("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        step();
        for (int k = 1; k <= lat; k++) begin
            chk_bit("busy_ready", req_ready, 1'b0);
            chk_bit("rsp_valid", rsp_valid, k == lat);
            chk_bit("mem_en", mem_en, (k == 1) && !err);
            chk_bit("mem_we", mem_we, (k == 1) && !err && w);
            if (k == 1 && !err) begin
                chk_word("mem_addr", mem_addr, a);
                if (w) chk_word("mem_wdata", mem_wdata, d);
            end
            if (k == lat) begin
                chk_word("rsp_rdata", rsp_rdata, exp_rd);
                chk_bit("rsp_err", rsp_err, err);
            end
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = 16'($urandom_range(0, 63));
            req_wdata = 16'($urandom);
            step();
        end
        req_valid = 1'b0;
        chk_bit("rsp_done", rsp_valid, 1'b0);
        chk_word("rdata_hold", rsp_rdata, exp_rd);
    endtask

    initial begin
        int          acc_cyc[$];
        int          rsp_n;
        logic        w;
        logic [15:0] a;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        step();

        // Preload SRAM and model while in reset.
        pre_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            pre_addr   = 8'(i);
            pre_data   = (i == 16) ? 16'hBEEF : 16'($urandom);
            ref_mem[i] = pre_data;
            step();
        end
        pre_we = 1'b0;
        step();
        reset = 1'b0;

        chk_bit("rst_ready", req_ready, 1'b1);
        chk_bit("rst_rsp_valid", rsp_valid, 1'b0);
        chk_bit("rst_rsp_err", rsp_err, 1'b0);
        chk_word("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk_bit("rst_mem_en", mem_en, 1'b0);
        chk_bit("rst_mem_we", mem_we, 1'b0);
        chk_word("rst_mem_addr", mem_addr, 16'h0000);
        chk_word("rst_mem_wdata", mem_wdata, 16'h0000);

        // Preloaded read, then write-then-read.
        transact(1'b0, 16'h0010, 16'h0000);
        transact(1'b1, 16'h0020, 16'h1234);
        transact(1'b0, 16'h0020, 16'h0000);
`ifdef MEM_PORT_ERR_EN
        transact(1'b0, 16'h0100, 16'h0000);
        transact(1'b1, 16'hFFFF, 16'h5A5A);
`endif

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom);
            a = 16'($urandom_range(0, 63));
`ifdef MEM_PORT_ERR_EN
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(256, 65535));
`endif
            transact(w, a, 16'($urandom));
        end

        // Back-to-back: req_valid held high until three accepts.
        rsp_n     = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0010;
        for (int c = 0; c < 3 * (WAIT + 3) + 2; c++) begin
            if (req_valid && req_ready) acc_cyc.push_back(c);
            if (rsp_valid) begin
                rsp_n++;
                chk_word("b2b_rdata", rsp_rdata, ref_mem[16]);
            end
            step();
            if (acc_cyc.size() == 3) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk_int("b2b_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk_int("b2b_gap1", acc_cyc[1] - acc_cyc[0], WAIT + 3);
            chk_int("b2b_gap2", acc_cyc[2] - acc_cyc[1], WAIT + 3);
        end
        chk_int("b2b_rsp_count", rsp_n, 3);

        // Reset during WAIT of a read, with req_valid high during reset.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0011;
        step();
        req_valid = 1'b0;
        chk_bit("mr_issue_en", mem_en, 1'b1);
        step();
        reset     = 1'b1;
        req_valid = 1'b1;
        step();
        chk_bit("mr_en_off", mem_en, 1'b0);
        chk_bit("mr_no_rsp", rsp_valid, 1'b0);
        chk_bit("mr_ready", req_ready, 1'b1);
        chk_word("mr_rdata_clr", rsp_rdata, 16'h0000);
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < WAIT + 4; c++) begin
            step();
            chk_bit("post_rst_ready", req_ready, 1'b1);
            chk_bit("post_rst_rsp", rsp_valid, 1'b0);
            chk_bit("post_rst_en", mem_en, 1'b0);
        end

        // Controller still works after an abandoned transaction.
        transact(1'b0, 16'h0020, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
